// File: rtl/plic_pkg.sv
// plic_pkg: shared definitions for the plic_lite interrupt controller.
//   - register byte offsets on the 10-bit bus port
//   - per-source gateway state encoding
//   - bit position of the machine external interrupt pending flag in mip
package plic_pkg;

    localparam logic [9:0] PRIO_BASE = 10'h000;
    localparam logic [9:0] PEND_OFF  = 10'h080;
    localparam logic [9:0] EN_OFF    = 10'h100;
    localparam logic [9:0] THR_OFF   = 10'h200;
    localparam logic [9:0] CLAIM_OFF = 10'h204;

    localparam int MEIP_BIT = 11;

    typedef enum logic [1:0] {
        GW_IDLE     = 2'd0,
        GW_PENDING  = 2'd1,
        GW_INFLIGHT = 2'd2
    } gw_state_t;

endpackage

// File: rtl/plic_gateway.sv
// plic_gateway: per-source interrupt gateway. Converts a level interrupt
// line into a single pending request and blocks further requests until
// software completes the one in flight.
//
// Ports:
//   clk      in   core clock
//   reset    in   synchronous active-high reset
//   irq      in   level interrupt line for this source
//   claim    in   this source is being claimed this cycle
//   complete in   a complete write naming this source this cycle
//   pending  out  registered pending flag (1 while in PENDING)
//
// state       | meaning
// ------------+--------------------------------------------------------
// GW_IDLE     | no request outstanding; a high line raises a request
// GW_PENDING  | request visible to the arbiter, waiting for a claim
// GW_INFLIGHT | claimed by software; line ignored until completed
module plic_gateway
    import plic_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic claim,
    input  logic complete,
    output logic pending
);

    gw_state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= GW_IDLE;
            pending <= 1'b0;
        end else begin
            case (state)
                GW_IDLE: begin
                    if (irq) begin
                        state   <= GW_PENDING;
                        pending <= 1'b1;
                    end
                end
                GW_PENDING: begin
                    // A claim beats a concurrent line change: the source
                    // always leaves PENDING for INFLIGHT here.
                    if (claim) begin
                        state   <= GW_INFLIGHT;
                        pending <= 1'b0;
                    end
                end
                GW_INFLIGHT: begin
                    if (complete) begin
                        state   <= GW_IDLE;
                        pending <= 1'b0;
                    end
                end
                default: begin
                    state   <= GW_IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/plic_lite.sv
// plic_lite: minimal platform-level interrupt controller.
// Gathers NSRC level interrupt lines (ID 0 reserved) through per-source
// gateways, arbitrates pending & enabled sources by priority above a
// threshold, and drives meip toward mip[MEIP_BIT] in the CSR file.
// Software claims (read) and completes (write) through the CLAIM register.
//
// Ports:
//   clk         in   core clock
//   reset       in   synchronous active-high reset
//   irq_src     in   level interrupt lines, bit 0 ignored
//   bus_valid   in   single-cycle register access request
//   bus_we      in   1 = write, 0 = read
//   bus_addr    in   byte offset, bits [1:0] ignored
//   bus_wdata   in   write data
//   bus_rdata   out  read data, one cycle after the request
//   bus_rvalid  out  read-data strobe
//   meip        out  machine external interrupt pending
module plic_lite
    import plic_pkg::*;
#(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 3,
    parameter int ID_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NSRC-1:0]   irq_src,
    input  logic              bus_valid,
    input  logic              bus_we,
    input  logic [9:0]        bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              bus_rvalid,
    output logic              meip
);

    logic [PRIO_W-1:0] prio_q [NSRC];
    logic [NSRC-1:0]   en_q;
    logic [PRIO_W-1:0] thr_q;
    logic [NSRC-1:0]   pend;

    logic [ID_W-1:0]   best_id_q;
    logic [PRIO_W-1:0] best_prio_q;
    logic [ID_W-1:0]   win_id;
    logic [PRIO_W-1:0] win_prio;

    logic [9:0]  addr_w;
    logic [4:0]  prio_idx;
    logic        is_prio;
    logic        wr;
    logic        rd;
    logic        claim_rd;
    logic        cmpl_wr;
    logic [ID_W-1:0] cmpl_id;
    logic [31:0] rd_val;

    assign addr_w   = {bus_addr[9:2], 2'b00};
    assign prio_idx = bus_addr[6:2];
    assign is_prio  = (addr_w[9:7] == PRIO_BASE[9:7]) && ({27'd0, prio_idx} < 32'(NSRC));
    assign wr       = bus_valid &  bus_we;
    assign rd       = bus_valid & ~bus_we;
    assign claim_rd = rd && (addr_w == CLAIM_OFF);
    assign cmpl_wr  = wr && (addr_w == CLAIM_OFF);
    assign cmpl_id  = bus_wdata[ID_W-1:0];

    // Gateways. ID 0 has none; IDs >= NSRC never match a gateway, so an
    // out-of-range complete falls away naturally.
    assign pend[0] = 1'b0;

    for (genvar g = 1; g < NSRC; g++) begin : g_gw
        plic_gateway u_gw (
            .clk      (clk),
            .reset    (reset),
            .irq      (irq_src[g]),
            .claim    (claim_rd && (best_id_q == ID_W'(g))),
            .complete (cmpl_wr && (cmpl_id == ID_W'(g))),
            .pending  (pend[g])
        );
    end

    // Arbiter: seeding the running best with the threshold folds the
    // threshold compare into the search; the strict '>' keeps ties on
    // the lowest ID since IDs are scanned upward.
    always_comb begin
        win_id   = '0;
        win_prio = thr_q;
        for (int i = 1; i < NSRC; i++) begin
            if (pend[i] && en_q[i] && (prio_q[i] > win_prio)) begin
                win_id   = ID_W'(i);
                win_prio = prio_q[i];
            end
        end
    end

    // Read mux. CLAIM returns the registered winner, i.e. the arbitration
    // result from before any write in the same cycle.
    always_comb begin
        rd_val = '0;
        case (addr_w)
            PEND_OFF:  rd_val = 32'(pend);
            EN_OFF:    rd_val = 32'(en_q);
            THR_OFF:   rd_val = 32'(thr_q);
            CLAIM_OFF: rd_val = 32'(best_id_q);
            default: begin
                if (is_prio) begin
                    for (int i = 1; i < NSRC; i++) begin
                        if (prio_idx == 5'(i)) begin
                            rd_val = 32'(prio_q[i]);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NSRC; i++) begin
                prio_q[i] <= '0;
            end
            en_q        <= '0;
            thr_q       <= '0;
            best_id_q   <= '0;
            best_prio_q <= '0;
            meip        <= 1'b0;
            bus_rdata   <= '0;
            bus_rvalid  <= 1'b0;
        end else begin
            bus_rvalid  <= rd;
            bus_rdata   <= rd ? rd_val : 32'd0;

            best_id_q   <= win_id;
            best_prio_q <= (win_id != '0) ? win_prio : '0;
            meip        <= (win_id != '0);

            if (wr) begin
                if (addr_w == EN_OFF) begin
                    en_q <= {bus_wdata[NSRC-1:1], 1'b0};
                end
                if (addr_w == THR_OFF) begin
                    thr_q <= bus_wdata[PRIO_W-1:0];
                end
                for (int i = 1; i < NSRC; i++) begin
                    if (is_prio && (prio_idx == 5'(i))) begin
                        prio_q[i] <= bus_wdata[PRIO_W-1:0];
                    end
                end
            end
        end
    end

    // Bits with no function in this controller: sub-word address bits,
    // the reserved source line, upper write data and the winner priority,
    // which is kept registered for observation alongside best_id.
    logic unused_bits;
    assign unused_bits = ^{bus_addr[1:0], bus_wdata, irq_src[0], best_prio_q};

endmodule

// File: doc/plic_lite.md
Name: plic_lite

Overview:
- Minimal platform-level interrupt controller. Sits directly upstream of the trap handler.
- Collects NSRC level-sensitive external interrupt lines and gates each through a per-source gateway.
- Arbitrates by priority against a threshold and drives the machine external interrupt pending bit (mip[11]) to the CSR file.
- Software claims and completes interrupts through a small memory-mapped register port on the data bus.

Parameters:
- NSRC, 8, number of source IDs including reserved ID 0; legal range 2..32.
- PRIO_W, 3, width of priority and threshold fields.
- ID_W, 5, width of source ID fields; must satisfy 2^ID_W >= NSRC.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- irq_src  in  NSRC  level interrupt lines; bit 0 is ignored.
- bus_valid  in  1  register-access request, single cycle.
- bus_we  in  1  1 = write, 0 = read.
- bus_addr  in  10  byte offset; word aligned, bits [1:0] ignored.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, valid the cycle after bus_valid.
- bus_rvalid  out  1  read-data strobe.
- meip  out  1  external interrupt pending, to CSR mip[11].

Behaviour:
- Register map:
  - 0x000+4*i: priority[i], RW, low PRIO_W bits. Index 0 reads 0 and ignores writes.
  - 0x080: pending bits, RO.
  - 0x100: enable bits, RW; bit 0 is forced to 0.
  - 0x200: threshold, RW.
  - 0x204: claim on read, complete on write.
  - Unmapped reads return 0; unmapped writes are ignored.
- Reset values: all priorities, enables, threshold and pending bits = 0; all gateways IDLE; meip=0; bus_rdata=0; bus_rvalid=0.
- Gateway per source i>=1, 3 states:
  - IDLE -> PENDING when irq_src[i]=1 at the edge; pending[i] is set the next cycle.
  - PENDING -> INFLIGHT on a claim returning i; pending[i] is cleared.
  - INFLIGHT ignores irq_src[i]. INFLIGHT -> IDLE on a complete write with wdata[ID_W-1:0]=i.
  - If the line is still high after complete, the source re-pends on the following edge.
- Arbiter:
  - Candidate = pending & enable & (priority > threshold).
  - Winner = highest priority; ties go to the lowest ID.
  - best_id and best_prio are registered each cycle; best_id=0 when there is no candidate.
  - meip is registered as (best_id != 0).
  - Latency: irq_src rises at edge t -> pending at t+1 -> meip at t+2.
- Claim (read 0x204):
  - bus_rdata = best_id as registered at the access cycle. The winning gateway goes INFLIGHT at the same edge.
  - Reading 0 has no side effect.
  - meip drops 2 cycles later unless another candidate exists.
- Complete (write 0x204):
  - Ignored if the ID is 0, >= NSRC, or that gateway is not INFLIGHT.
- Priority 0 or threshold = max priority: the source can never interrupt, but its pending bit still latches.
- Simultaneous events in one cycle:
  - A claim of i and irq_src[i] rising: claim wins, the source goes INFLIGHT.
  - Enable/threshold/priority writes take effect on the arbiter the next cycle.
  - A claim read sees pre-write arbitration.
- Reset asserted mid-operation returns every register and gateway to its reset value in that cycle. No interrupt survives reset.
- bus_rvalid is 1 exactly one cycle after each read request and 0 after writes.

Decomposition:
- Shared package (plic_pkg):
  - register offset constants: PRIO_BASE, PEND_OFF, EN_OFF, THR_OFF, CLAIM_OFF;
  - gateway state encoding;
  - MEIP_BIT=11.
- One sub-module, plic_gateway, holding the per-source 3-state FSM. It is instantiated NSRC-1 times via generate.
- Arbiter and register file stay in plic_lite.

Test Plan:
- Reset, prio[3]=2, en=0x08, thr=0, pulse irq_src[3] -> pending=0x08 at t+1, meip=1 at t+2; claim read returns 3; meip=0 two cycles later.
- prio[2]=5, prio[5]=5, prio[6]=4, all enabled and raised -> claims return 2, then 5, then 6 (each completed before the next claim); final claim returns 0.
- thr=5, prio[4]=5, irq_src[4]=1 -> pending[4]=1, meip stays 0; then write thr=4 -> meip=1 two cycles later.
- Claim 3 with irq_src[3] held high -> no re-pend while INFLIGHT. Complete with ID 7 -> ignored. Complete with ID 3 -> pending[3]=1 next cycle.
- Same cycle: claim read while irq_src[1] rises, prio[1] > current winner -> claim returns old winner; subsequent claim returns 1.
- Assert reset while source 2 is INFLIGHT and meip=1 -> next cycle meip=0, all registers 0; claim returns 0.
